// File: rtl/amm_burst_mem_slave.sv
// amm_burst_mem_slave
//
// Avalon-MM burst-capable slave backed by an internal word memory. It is
// the responder that a memory-checker master talks to, and it also serves
// as on-chip scratch memory. Single and burst writes honour byteenable;
// single and burst reads return data after a fixed latency. The slave
// flags a protocol violation when the master issues an illegal command.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   address       word address, sampled on the first beat of a burst only
//   read          read request
//   write         write request / write beat
//   byteenable    per-byte write enable (ignored for reads)
//   burstcount    burst length in beats, 0 behaves as 1
//   writedata     write beat data
//   readdata      read beat data, holds its value between beats
//   readdatavalid readdata valid this cycle
//   waitrequest   slave cannot accept a command this cycle
//   proto_err     sticky protocol-violation flag, cleared only by reset

module amm_burst_mem_slave #(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 32,
    parameter int BURST_W      = 11,
    parameter int READ_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   address,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic [BURST_W-1:0]  burstcount,
    input  logic [DATA_W-1:0]   writedata,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                waitrequest,
    output logic                proto_err
);

    localparam int BE_W     = DATA_W / 8;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int LAT_W    = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
    // RD_WAIT lasts READ_LATENCY-1 cycles; the counter runs down to zero.
    localparam int LAT_LOAD = (READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WR_BURST = 2'd1;
    localparam logic [1:0] RD_WAIT  = 2'd2;
    localparam logic [1:0] RD_BURST = 2'd3;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [1:0]         state;
    logic [ADDR_W-1:0]  ptr;
    logic [BURST_W-1:0] remaining;
    logic [LAT_W-1:0]   lat_cnt;
    logic [BURST_W-1:0] req_count;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0]  merged;

    assign req_count   = (burstcount == '0) ? BURST_W'(1) : burstcount;
    assign waitrequest = (state == RD_WAIT) || (state == RD_BURST);

    // Write port: beat 0 uses the bus address, later beats use the burst
    // pointer. The new word is the stored word with enabled bytes replaced.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = address;
        if (state == IDLE && write) begin
            mem_we    = 1'b1;
            mem_waddr = address;
        end else if (state == WR_BURST && write) begin
            mem_we    = 1'b1;
            mem_waddr = ptr;
        end
        merged = mem[mem_waddr];
        for (int i = 0; i < BE_W; i++) begin
            if (byteenable[i]) begin
                merged[8*i +: 8] = writedata[8*i +: 8];
            end
        end
    end

    // Memory has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= merged;
        end
    end

    // Command FSM. remaining counts beats not yet written/emitted; the
    // pointer wraps naturally at ADDR_W bits. readdatavalid is registered
    // and is set on the edge that emits a beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            remaining     <= '0;
            lat_cnt       <= '0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
            proto_err     <= 1'b0;
        end else begin
            readdatavalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (write) begin
                        // A simultaneous read is dropped and flagged.
                        if (read) begin
                            proto_err <= 1'b1;
                        end
                        if (req_count != BURST_W'(1)) begin
                            ptr       <= address + ADDR_W'(1);
                            remaining <= req_count - BURST_W'(1);
                            state     <= WR_BURST;
                        end
                    end else if (read) begin
                        if (READ_LATENCY == 1) begin
                            // Beat 0 must appear in the cycle right after accept.
                            readdata      <= mem[address];
                            readdatavalid <= 1'b1;
                            ptr           <= address + ADDR_W'(1);
                            remaining     <= req_count - BURST_W'(1);
                            state         <= RD_BURST;
                        end else begin
                            ptr       <= address;
                            remaining <= req_count;
                            lat_cnt   <= LAT_W'(LAT_LOAD);
                            state     <= RD_WAIT;
                        end
                    end
                end
                WR_BURST: begin
                    if (read) begin
                        proto_err <= 1'b1;
                    end
                    if (write) begin
                        ptr       <= ptr + ADDR_W'(1);
                        remaining <= remaining - BURST_W'(1);
                        if (remaining == BURST_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == '0) begin
                        readdata      <= mem[ptr];
                        readdatavalid <= 1'b1;
                        ptr           <= ptr + ADDR_W'(1);
                        remaining     <= remaining - BURST_W'(1);
                        state         <= RD_BURST;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                RD_BURST: begin
                    if (remaining != '0) begin
                        readdata      <= mem[ptr];
                        readdatavalid <= 1'b1;
                        ptr           <= ptr + ADDR_W'(1);
                        remaining     <= remaining - BURST_W'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_amm_burst_mem_slave.sv
// tb_amm_burst_mem_slave
//
// Directed self-checking bench for amm_burst_mem_slave with default
// parameters (16 words x 32 bits, READ_LATENCY=2). Inputs change and
// outputs are sampled 1 time unit after each rising edge.

module tb_amm_burst_mem_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [10:0] burstcount;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_buf [0:31];
    int          rd_n;
    bit          rd_gap;
    bit          rd_timeout;

    amm_burst_mem_slave #(
        .ADDR_W(4), .DATA_W(32), .BURST_W(11), .READ_LATENCY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .read(read),
        .write(write), .byteenable(byteenable), .burstcount(burstcount),
        .writedata(writedata), .readdata(readdata),
        .readdatavalid(readdatavalid), .waitrequest(waitrequest),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        address    = a;
        writedata  = d;
        byteenable = be;
        burstcount = 11'd1;
        write      = 1'b1;
        tick();
        write = 1'b0;
    endtask

    // Issues a read and gathers beats until waitrequest drops.
    task automatic do_read(input logic [3:0] a, input logic [10:0] bc);
        bit started = 0;
        bit ended = 0;
        rd_n       = 0;
        rd_gap     = 0;
        rd_timeout = 1;
        address    = a;
        burstcount = bc;
        read       = 1'b1;
        tick();
        read = 1'b0;
        for (int c = 0; c < 64; c++) begin
            if (readdatavalid) begin
                if (ended) rd_gap = 1;
                if (rd_n < 32) rd_buf[rd_n] = readdata;
                rd_n++;
                started = 1;
            end else if (started) begin
                ended = 1;
            end
            if (!waitrequest) begin
                rd_timeout = 0;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        address    = '0;
        read       = 1'b0;
        write      = 1'b0;
        byteenable = '0;
        burstcount = '0;
        writedata  = '0;
        #12;
        checks++; if (waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL reset_waitrequest got %b want 0", waitrequest); end
        checks++; if (readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rdv got %b want 0", readdatavalid); end
        checks++; if (readdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_readdata got %h want 0", readdata); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_proto_err got %b want 0", proto_err); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_rw();
        do_write(4'd3, 32'hDEADBEEF, 4'hF);
        address    = 4'd3;
        burstcount = 11'd1;
        read       = 1'b1;
        tick();
        read = 1'b0;
        checks++; if (waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL single_wr_n1 got %b want 1", waitrequest); end
        checks++; if (readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL single_rdv_n1 got %b want 0", readdatavalid); end
        tick();
        checks++; if (waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL single_wr_n2 got %b want 1", waitrequest); end
        checks++; if (readdatavalid !== 1'b1) begin errors++; $display("[TB] FAIL single_rdv_n2 got %b want 1", readdatavalid); end
        checks++; if (readdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_data got %h want deadbeef", readdata); end
        tick();
        checks++; if (waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL single_wr_n3 got %b want 0", waitrequest); end
        checks++; if (readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL single_rdv_n3 got %b want 0", readdatavalid); end
        checks++; if (readdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_hold got %h want deadbeef", readdata); end
    endtask

    task automatic test_byteenable();
        do_write(4'd5, 32'h11223344, 4'hF);
        do_write(4'd5, 32'hAABBCCDD, 4'b0101);
        do_read(4'd5, 11'd1);
        checks++; if (rd_n !== 1 || rd_timeout) begin errors++; $display("[TB] FAIL be_beats got %0d (timeout %0d) want 1", rd_n, rd_timeout); end
        checks++; if (rd_buf[0] !== 32'h11BB33DD) begin errors++; $display("[TB] FAIL be_data got %h want 11bb33dd", rd_buf[0]); end
    endtask

    task automatic test_wrap_burst();
        logic [31:0] exp [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
        do_write(4'd9, 32'h99, 4'hF);
        address    = 4'd14;
        burstcount = 11'd4;
        byteenable = 4'hF;
        writedata  = 32'd1;
        write      = 1'b1;
        tick();
        address    = 4'd9;
        burstcount = 11'd7;
        writedata  = 32'd2;
        tick();
        checks++; if (waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL wrburst_wr got %b want 0", waitrequest); end
        write     = 1'b0;
        writedata = 32'hBAD;
        tick();
        write     = 1'b1;
        writedata = 32'd3;
        tick();
        writedata = 32'd4;
        tick();
        write = 1'b0;
        do_read(4'd14, 11'd4);
        checks++; if (rd_n !== 4 || rd_timeout) begin errors++; $display("[TB] FAIL wrap_beats got %0d (timeout %0d) want 4", rd_n, rd_timeout); end
        checks++; if (rd_gap) begin errors++; $display("[TB] FAIL wrap_gap got gap want none"); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (rd_buf[k] !== exp[k]) begin errors++; $display("[TB] FAIL wrap_beat%0d got %h want %h", k, rd_buf[k], exp[k]); end
        end
        do_read(4'd0, 11'd1);
        checks++; if (rd_buf[0] !== 32'd3) begin errors++; $display("[TB] FAIL wrap_addr0 got %h want 3", rd_buf[0]); end
        do_read(4'd9, 11'd1);
        checks++; if (rd_buf[0] !== 32'h99) begin errors++; $display("[TB] FAIL wrap_addr9 got %h want 99", rd_buf[0]); end
    endtask

    task automatic test_burstcount_zero();
        do_write(4'd2, 32'h00002222, 4'hF);
        do_read(4'd2, 11'd0);
        checks++; if (rd_n !== 1 || rd_timeout) begin errors++; $display("[TB] FAIL bc0_beats got %0d (timeout %0d) want 1", rd_n, rd_timeout); end
        checks++; if (rd_buf[0] !== 32'h00002222) begin errors++; $display("[TB] FAIL bc0_data got %h want 2222", rd_buf[0]); end
        checks++; if (waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL bc0_idle got %b want 0", waitrequest); end
    endtask

    task automatic test_rw_collision();
        int rdv_seen = 0;
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL coll_pre got %b want 0", proto_err); end
        address    = 4'd7;
        burstcount = 11'd1;
        byteenable = 4'hF;
        writedata  = 32'h55;
        write      = 1'b1;
        read       = 1'b1;
        tick();
        write = 1'b0;
        read  = 1'b0;
        checks++; if (proto_err !== 1'b1) begin errors++; $display("[TB] FAIL coll_err got %b want 1", proto_err); end
        checks++; if (waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL coll_wr got %b want 0", waitrequest); end
        for (int c = 0; c < 4; c++) begin
            if (readdatavalid) rdv_seen++;
            tick();
        end
        checks++; if (rdv_seen !== 0) begin errors++; $display("[TB] FAIL coll_rdv got %0d beats want 0", rdv_seen); end
        do_read(4'd7, 11'd1);
        checks++; if (rd_buf[0] !== 32'h55) begin errors++; $display("[TB] FAIL coll_data got %h want 55", rd_buf[0]); end
        checks++; if (proto_err !== 1'b1) begin errors++; $display("[TB] FAIL coll_sticky got %b want 1", proto_err); end
    endtask

    task automatic test_reset_mid_read();
        int seen = 0;
        bit hit = 0;
        address    = 4'd14;
        burstcount = 11'd4;
        read       = 1'b1;
        tick();
        read = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (readdatavalid) seen++;
            if (seen == 2) begin
                hit = 1;
                break;
            end
            tick();
        end
        checks++; if (!hit) begin errors++; $display("[TB] FAIL midrst_start got %0d beats want 2", seen); end
        rst_n = 1'b0;
        #1;
        checks++; if (readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rdv got %b want 0", readdatavalid); end
        checks++; if (waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL midrst_wr got %b want 0", waitrequest); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_err got %b want 0", proto_err); end
        checks++; if (readdata !== 32'h0) begin errors++; $display("[TB] FAIL midrst_data got %h want 0", readdata); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_read(4'd14, 11'd4);
        checks++; if (rd_n !== 4 || rd_timeout) begin errors++; $display("[TB] FAIL midrst_beats got %0d (timeout %0d) want 4", rd_n, rd_timeout); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (rd_buf[k] !== 32'(k + 1)) begin errors++; $display("[TB] FAIL midrst_beat%0d got %h want %h", k, rd_buf[k], k + 1); end
        end
    endtask

    initial begin
        $display("[TB] starting amm_burst_mem_slave bench");
        test_reset();
        test_single_rw();
        test_byteenable();
        test_wrap_burst();
        test_burstcount_zero();
        test_rw_collision();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
